battleship_vga_grid: RTL and testbench
======================================

# battleship_vga_grid

Downstream display stage for `battleship_top`: consumes the 100-cell `cell_state_flat` board and the cursor position, and drives a 640x480@60 VGA output. It draws a 10x10 grid, colours each cell by state and outlines the selected cell. Board inputs are snapshotted once per frame, so the image never tears.

## Interface
- `CLK_DIV`, 4: system clocks per pixel tick (100 MHz / 4 = 25 MHz).
- `GRID_X0`, 120: left pixel column of the grid.
- `GRID_Y0`, 40: top pixel row of the grid.
- `CELL_PX`, 40: cell edge in pixels; the grid is 10*CELL_PX square.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `cell_state_flat`  in  400  cell n state at bits [n*4 +: 4], n = row*10+col.
- `selected_cell`  in  7  cursor cell, 0-99; values >99 mean no cursor.
- `vga_hsync`  out  1  active-low.
- `vga_vsync`  out  1  active-low.
- `vga_r`, `vga_g`, `vga_b`  out  4 each  colour; 0 outside the active area.
- `frame_start`  out  1  one-clk pulse on the tick where h=0, v=0 enters stage 0.

## Operation
- Tick divider: `div_cnt` counts 0..CLK_DIV-1. `pix_tick` is high when `div_cnt`==CLK_DIV-1. All pixel-domain registers advance only on `pix_tick`.
- Horizontal counter `h`: 0..799 (640 active, 16 front porch, 96 sync at 656-751, 48 back porch).
- Vertical counter `v`: 0..524 (480 active, 10 front porch, 2 sync at 490-491, 33 back porch). `v` increments when `h` wraps 799->0.
- Snapshot: on the tick where v=480, h=0, latch `cell_state_flat` and `selected_cell` into shadow registers. Rendering uses only the shadows.
- Stage 1 (registered): `in_grid`, `col`=(h-GRID_X0)/CELL_PX, `row`=(v-GRID_Y0)/CELL_PX, in-cell offsets `ox`, `oy`, `active`=(h<640 && v<480). Division is by comparison or counters; no `/` operator on a non-constant divisor.
- Stage 2 (registered): colour selection, priority highest first:
  1. not `active` -> 0x000.
  2. not `in_grid` -> 0x000.
  3. `ox`==0 or `oy`==0, or the pixel is on the last grid row/column (x = GRID_X0+400 or y = GRID_Y0+400, inclusive) -> gridline 0x888.
  4. cell == shadow `selected_cell` and (`ox` or `oy` in {1, 2, CELL_PX-2, CELL_PX-1}) -> cursor 0xFF0.
  5. Cell state 0 water -> 0x00A; 1 miss -> 0xFFF; 2 hit -> 0xF00; 3 sunk -> 0x800; 4-15 -> 0x00A.
- hsync and vsync are computed from stage-0 `h`/`v` and delayed through 2 registers, so they stay aligned with RGB.

## Timing
- Reset values: `div_cnt`=0, `h`=0, `v`=0, shadows=0, pipeline registers=0, `vga_hsync`=1, `vga_vsync`=1, RGB=0, `frame_start`=0.
- Latency: RGB and sync for counter position (h,v) appear 2 pixel ticks (2*CLK_DIV clocks) after the counters hold (h,v).
- The first `frame_start` occurs one full frame (800*525 ticks) after reset release. The counters start at (0,0) but no pulse is issued on the reset-exit tick.
- The snapshot takes effect from the next active line 0. Input changes during an active frame are invisible until the next frame.
- A reset asserted mid-frame returns every register to its reset value on the next clk edge. The next snapshot occurs at v=480.
- The shadow `selected_cell` of 0 after reset means cell 0 is outlined once the first snapshot is taken. Before that, the all-zero shadows render cell 0 outlined and all cells as water.

## Test plan
- Reset, then run 2 lines: RGB=0 and hsync=1 during reset. hsync falls exactly 2+656 ticks after h=0 and stays low for 96 ticks. Line period is 800 ticks (3200 clks).
- Run 1 frame: vsync is low for exactly 2 lines (1600 ticks) starting at line 490 (+2 ticks latency). `frame_start` period is 420000 ticks.
- Set cell 23 to state 2 and cell 0 to state 1 before v=480. Next frame: pixel (GRID_X0+3*40+20, GRID_Y0+2*40+20) = 0xF00. Pixel (140,60) = 0xFFF. Pixel (GRID_X0, any grid y) = 0x888.
- Set `selected_cell`=45. Next frame: pixel (GRID_X0+5*40+1, GRID_Y0+4*40+20) = 0xFF0. The cell centre shows its state colour.
- Change cell 23 from 2 to 3 at v=100. Row 2 still shows 0xF00 in this frame and 0x800 in the next.
- Assert reset for 1 clk at h=300, v=200: all outputs return to reset values, `h`=`v`=0, and the shadows clear to water with cell 0 selected.

Source files
------------

// File: rtl/battleship_vga_grid_if.sv
// Board-to-display bundle: board snapshot inputs plus the VGA pins.
// The display stage (slave) consumes the board and drives sync/colour/frame_start.
interface battleship_vga_grid_if;
   logic [399:0] cell_state_flat;
   logic [6:0]   selected_cell;
   logic         vga_hsync;
   logic         vga_vsync;
   logic [3:0]   vga_r;
   logic [3:0]   vga_g;
   logic [3:0]   vga_b;
   logic         frame_start;

   modport master (
      output cell_state_flat,
      output selected_cell,
      input  vga_hsync,
      input  vga_vsync,
      input  vga_r,
      input  vga_g,
      input  vga_b,
      input  frame_start
   );

   modport slave (
      input  cell_state_flat,
      input  selected_cell,
      output vga_hsync,
      output vga_vsync,
      output vga_r,
      output vga_g,
      output vga_b,
      output frame_start
   );
endinterface

// File: rtl/battleship_vga_grid.sv
// VGA renderer for the 10x10 battleship board: counters, per-frame board snapshot,
// a 2-stage pixel pipeline (geometry, then colour) with sync delayed to match.
module battleship_vga_grid #(
   parameter int CLK_DIV  = 4,
   parameter int GRID_X0  = 120,
   parameter int GRID_Y0  = 40,
   parameter int CELL_PX  = 40,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic clk,
   input  logic reset,
   battleship_vga_grid_if.slave bus
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int OW = (CELL_PX > 2) ? $clog2(CELL_PX) : 1;

   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [9:0]    H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0]    V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0]    H_ACT_L   = 10'(H_ACTIVE);
   localparam logic [9:0]    V_ACT_L   = 10'(V_ACTIVE);
   localparam logic [9:0]    HS_FIRST  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]    HS_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0]    VS_FIRST  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]    VS_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [9:0]    X0_L      = 10'(GRID_X0);
   localparam logic [9:0]    X1_L      = 10'(GRID_X0 + 10 * CELL_PX);
   localparam logic [9:0]    Y0_L      = 10'(GRID_Y0);
   localparam logic [9:0]    Y1_L      = 10'(GRID_Y0 + 10 * CELL_PX);
   localparam logic [OW-1:0] OFF_ZERO  = OW'(0);
   localparam logic [OW-1:0] EDGE_A    = OW'(1);
   localparam logic [OW-1:0] EDGE_B    = OW'(2);
   localparam logic [OW-1:0] EDGE_C    = OW'(CELL_PX - 2);
   localparam logic [OW-1:0] EDGE_D    = OW'(CELL_PX - 1);

   logic [DW-1:0]  div_cnt_r;
   logic [9:0]     h_r;
   logic [9:0]     v_r;
   logic           frame_start_r;
   logic [399:0]   shadow_cells_r;
   logic [6:0]     shadow_sel_r;

   logic           s1_active_r;
   logic           s1_in_grid_r;
   logic [3:0]     s1_col_r;
   logic [3:0]     s1_row_r;
   logic [OW-1:0]  s1_ox_r;
   logic [OW-1:0]  s1_oy_r;
   logic           s1_hsync_r;
   logic           s1_vsync_r;

   logic [11:0]    rgb_r;
   logic           hsync_r;
   logic           vsync_r;

   logic           pix_tick_s;
   logic [3:0]     col_s;
   logic [3:0]     row_s;
   logic [9:0]     base_x_s;
   logic [9:0]     base_y_s;
   logic [OW-1:0]  ox_s;
   logic [OW-1:0]  oy_s;
   logic           in_grid_s;
   logic           active_s;
   logic           hsync_s;
   logic           vsync_s;
   logic [6:0]     cell_idx_s;
   logic [3:0]     cell_state_s;
   logic           cursor_s;
   logic [11:0]    colour_s;

   // Stage-0 decode: pixel tick, cell coordinates by threshold compare, sync levels
   always_comb begin
      pix_tick_s = (div_cnt_r == DIV_LAST);
      col_s      = 4'd0;
      row_s      = 4'd0;
      base_x_s   = X0_L;
      base_y_s   = Y0_L;
      for (int k = 1; k <= 10; k++) begin
         col_s    = (h_r >= X0_L + 10'(k * CELL_PX)) ? 4'(k) : col_s;
         base_x_s = (h_r >= X0_L + 10'(k * CELL_PX)) ? X0_L + 10'(k * CELL_PX) : base_x_s;
         row_s    = (v_r >= Y0_L + 10'(k * CELL_PX)) ? 4'(k) : row_s;
         base_y_s = (v_r >= Y0_L + 10'(k * CELL_PX)) ? Y0_L + 10'(k * CELL_PX) : base_y_s;
      end
      ox_s      = OW'(h_r - base_x_s);
      oy_s      = OW'(v_r - base_y_s);
      in_grid_s = (h_r >= X0_L) && (h_r <= X1_L) && (v_r >= Y0_L) && (v_r <= Y1_L);
      active_s  = (h_r < H_ACT_L) && (v_r < V_ACT_L);
      hsync_s   = !((h_r >= HS_FIRST) && (h_r <= HS_LAST));
      vsync_s   = !((v_r >= VS_FIRST) && (v_r <= VS_LAST));
   end

   // Pixel divider, raster counters and the frame-start pulse on the wrap to (0,0)
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt_r     <= {DW{1'b0}};
         h_r           <= 10'd0;
         v_r           <= 10'd0;
         frame_start_r <= 1'b0;
      end else begin
         frame_start_r <= 1'b0;
         if (pix_tick_s) begin
            div_cnt_r <= {DW{1'b0}};
            if (h_r == H_LAST) begin
               h_r <= 10'd0;
               if (v_r == V_LAST) begin
                  v_r           <= 10'd0;
                  frame_start_r <= 1'b1;
               end else begin
                  v_r <= v_r + 10'd1;
               end
            end else begin
               h_r <= h_r + 10'd1;
            end
         end else begin
            div_cnt_r <= div_cnt_r + DW'(1);
         end
      end
   end

   // Board snapshot at the start of vertical blanking so a frame never mixes two boards
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_cells_r <= 400'd0;
         shadow_sel_r   <= 7'd0;
      end else if (pix_tick_s && (h_r == 10'd0) && (v_r == V_ACT_L)) begin
         shadow_cells_r <= bus.cell_state_flat;
         shadow_sel_r   <= bus.selected_cell;
      end else begin
         shadow_cells_r <= shadow_cells_r;
         shadow_sel_r   <= shadow_sel_r;
      end
   end

   // Stage 1: geometry registers
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_active_r  <= 1'b0;
         s1_in_grid_r <= 1'b0;
         s1_col_r     <= 4'd0;
         s1_row_r     <= 4'd0;
         s1_ox_r      <= OFF_ZERO;
         s1_oy_r      <= OFF_ZERO;
         s1_hsync_r   <= 1'b1;
         s1_vsync_r   <= 1'b1;
      end else if (pix_tick_s) begin
         s1_active_r  <= active_s;
         s1_in_grid_r <= in_grid_s;
         s1_col_r     <= col_s;
         s1_row_r     <= row_s;
         s1_ox_r      <= ox_s;
         s1_oy_r      <= oy_s;
         s1_hsync_r   <= hsync_s;
         s1_vsync_r   <= vsync_s;
      end else begin
         s1_active_r  <= s1_active_r;
         s1_in_grid_r <= s1_in_grid_r;
         s1_col_r     <= s1_col_r;
         s1_row_r     <= s1_row_r;
         s1_ox_r      <= s1_ox_r;
         s1_oy_r      <= s1_oy_r;
         s1_hsync_r   <= s1_hsync_r;
         s1_vsync_r   <= s1_vsync_r;
      end
   end

   // Stage-2 decode: cell lookup, cursor ring and colour priority
   always_comb begin
      cell_idx_s   = {3'd0, s1_row_r} * 7'd10 + {3'd0, s1_col_r};
      cell_state_s = 4'd0;
      for (int n = 0; n < 100; n++) begin
         cell_state_s = (cell_idx_s == 7'(n)) ? shadow_cells_r[n*4 +: 4] : cell_state_s;
      end
      cursor_s = (cell_idx_s == shadow_sel_r) &&
                 ((s1_ox_r == EDGE_A) || (s1_ox_r == EDGE_B) || (s1_ox_r == EDGE_C) || (s1_ox_r == EDGE_D) ||
                  (s1_oy_r == EDGE_A) || (s1_oy_r == EDGE_B) || (s1_oy_r == EDGE_C) || (s1_oy_r == EDGE_D));
      colour_s = 12'h000;
      if (!s1_active_r) begin
         colour_s = 12'h000;
      end else if (!s1_in_grid_r) begin
         colour_s = 12'h000;
      end else if ((s1_ox_r == OFF_ZERO) || (s1_oy_r == OFF_ZERO)) begin
         colour_s = 12'h888;
      end else if (cursor_s) begin
         colour_s = 12'hFF0;
      end else begin
         case (cell_state_s)
            4'd0:    colour_s = 12'h00A;
            4'd1:    colour_s = 12'hFFF;
            4'd2:    colour_s = 12'hF00;
            4'd3:    colour_s = 12'h800;
            default: colour_s = 12'h00A;
         endcase
      end
   end

   // Stage 2: output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         rgb_r   <= 12'h000;
         hsync_r <= 1'b1;
         vsync_r <= 1'b1;
      end else if (pix_tick_s) begin
         rgb_r   <= colour_s;
         hsync_r <= s1_hsync_r;
         vsync_r <= s1_vsync_r;
      end else begin
         rgb_r   <= rgb_r;
         hsync_r <= hsync_r;
         vsync_r <= vsync_r;
      end
   end

   assign bus.vga_r       = rgb_r[11:8];
   assign bus.vga_g       = rgb_r[7:4];
   assign bus.vga_b       = rgb_r[3:0];
   assign bus.vga_hsync   = hsync_r;
   assign bus.vga_vsync   = vsync_r;
   assign bus.frame_start = frame_start_r;
endmodule

// File: tb/tb_battleship_vga_grid.sv
// Directed bench for battleship_vga_grid on a shrunken raster (68x66, 6-pixel cells)
// so several frames fit in a short run; expected colours are hand-computed.
module tb_battleship_vga_grid;
   localparam int CLK_DIV = 2;
   localparam int H_TOT   = 68;
   localparam int V_TOT   = 66;
   localparam int F_TOT   = H_TOT * V_TOT;
   localparam int F_CLK   = F_TOT * CLK_DIV;

   logic clk;
   logic reset;
   battleship_vga_grid_if bus ();

   battleship_vga_grid #(
      .CLK_DIV(CLK_DIV), .GRID_X0(2), .GRID_Y0(1), .CELL_PX(6),
      .H_ACTIVE(60), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_ACTIVE(62), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   int m_div, m_h, m_v;
   int clk_cnt = 0;
   int fs_n = 0;
   int fs_t0 = -1;
   int fs_t1 = -1;
   logic [11:0] rgb;

   assign rgb = {bus.vga_r, bus.vga_g, bus.vga_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference raster position (counters as the display should hold them)
   always_ff @(posedge clk) begin
      if (reset) begin
         m_div <= 0; m_h <= 0; m_v <= 0;
      end else if (m_div == CLK_DIV - 1) begin
         m_div <= 0;
         if (m_h == H_TOT - 1) begin
            m_h <= 0;
            m_v <= (m_v == V_TOT - 1) ? 0 : m_v + 1;
         end else begin
            m_h <= m_h + 1;
         end
      end else begin
         m_div <= m_div + 1;
      end
   end

   always_ff @(posedge clk) clk_cnt <= reset ? 0 : clk_cnt + 1;

   always_ff @(negedge clk) begin
      if (bus.frame_start === 1'b1) begin
         fs_n <= fs_n + 1;
         if (fs_n == 0) fs_t0 <= clk_cnt;
         else if (fs_n == 1) fs_t1 <= clk_cnt;
      end
   end

   // Waits until the outputs show pixel (x,y): counters two ticks past it.
   task automatic wait_pixel(input int x, input int y);
      int target;
      int budget;
      target = (y * H_TOT + x + 2) % F_TOT;
      budget = 0;
      while ((m_v * H_TOT + m_h) != target && budget < 2 * F_CLK) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 2 * F_CLK) begin
         n_checks++; n_errors++;
         $display("FAIL wait_pixel (%0d,%0d) timeout", x, y);
      end
   endtask

   task automatic test_reset();
      bus.cell_state_flat = 400'd0;
      bus.selected_cell   = 7'd0;
      reset = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++; if (rgb !== 12'h000) begin n_errors++; $display("FAIL reset_rgb got %h want 000", rgb); end
      n_checks++; if (bus.vga_hsync !== 1'b1) begin n_errors++; $display("FAIL reset_hsync got %b want 1", bus.vga_hsync); end
      n_checks++; if (bus.vga_vsync !== 1'b1) begin n_errors++; $display("FAIL reset_vsync got %b want 1", bus.vga_vsync); end
      n_checks++; if (bus.frame_start !== 1'b0) begin n_errors++; $display("FAIL reset_fs got %b want 0", bus.frame_start); end
      reset = 1'b0;
   endtask

   task automatic test_first_frame();
      int px[4] = '{0, 3, 5, 2};
      int py[4] = '{4, 4, 4, 10};
      logic [11:0] pe[4] = '{12'h000, 12'hFF0, 12'h00A, 12'h888};
      for (int i = 0; i < 4; i++) begin
         wait_pixel(px[i], py[i]);
         n_checks++;
         if (rgb !== pe[i]) begin n_errors++; $display("FAIL first_frame (%0d,%0d) got %h want %h", px[i], py[i], rgb, pe[i]); end
      end
      bus.cell_state_flat[23*4 +: 4] = 4'd2;
      bus.cell_state_flat[0 +: 4]    = 4'd1;
      wait_pixel(23, 16);
      n_checks++;
      if (rgb !== 12'h00A) begin n_errors++; $display("FAIL no_tear_cell23 got %h want 00A", rgb); end
   endtask

   task automatic test_hsync();
      int hx[4] = '{61, 62, 65, 66};
      logic he[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int f0, f1, r0;
      logic prev;
      wait_pixel(59, 20);
      n_checks++; if (rgb !== 12'h00A) begin n_errors++; $display("FAIL active_edge got %h want 00A", rgb); end
      wait_pixel(60, 20);
      n_checks++; if (rgb !== 12'h000) begin n_errors++; $display("FAIL clip_inactive got %h want 000", rgb); end
      for (int i = 0; i < 4; i++) begin
         wait_pixel(hx[i], 20);
         n_checks++;
         if (bus.vga_hsync !== he[i]) begin n_errors++; $display("FAIL hsync_h%0d got %b want %b", hx[i], bus.vga_hsync, he[i]); end
      end
      f0 = -1; f1 = -1; r0 = -1;
      prev = bus.vga_hsync;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (prev && !bus.vga_hsync) begin
            if (f0 < 0) f0 = c;
            else if (f1 < 0) f1 = c;
         end
         if (!prev && bus.vga_hsync && f0 >= 0 && r0 < 0) r0 = c;
         prev = bus.vga_hsync;
      end
      n_checks++;
      if (f0 < 0 || f1 - f0 !== 136) begin n_errors++; $display("FAIL line_period got %0d want 136", f1 - f0); end
      n_checks++;
      if (r0 < 0 || r0 - f0 !== 8) begin n_errors++; $display("FAIL hsync_width got %0d want 8", r0 - f0); end
   endtask

   task automatic test_vsync();
      int vx[4] = '{67, 0, 67, 0};
      int vy[4] = '{62, 63, 64, 65};
      logic ve[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         wait_pixel(vx[i], vy[i]);
         n_checks++;
         if (bus.vga_vsync !== ve[i]) begin n_errors++; $display("FAIL vsync (%0d,%0d) got %b want %b", vx[i], vy[i], bus.vga_vsync, ve[i]); end
      end
   endtask

   task automatic test_frame_start(input int pulses);
      int c;
      c = 0;
      while (fs_n < pulses && c < 2 * F_CLK) begin @(negedge clk); c++; end
      repeat (4) @(negedge clk);
      n_checks++;
      if (fs_n !== pulses) begin n_errors++; $display("FAIL fs_count got %0d want %0d", fs_n, pulses); end
      n_checks++;
      if (pulses == 1 && fs_t0 !== F_CLK) begin n_errors++; $display("FAIL fs_first got %0d want %0d", fs_t0, F_CLK); end
      else if (pulses == 2 && fs_t1 !== 2 * F_CLK) begin n_errors++; $display("FAIL fs_second got %0d want %0d", fs_t1, 2 * F_CLK); end
   endtask

   task automatic test_snapshot();
      int px[6] = '{5, 2, 23, 33, 1, 20};
      int py[6] = '{4, 10, 16, 28, 30, 61};
      logic [11:0] pe[6] = '{12'hFFF, 12'h888, 12'hF00, 12'h00A, 12'h000, 12'h888};
      for (int i = 0; i < 6; i++) begin
         wait_pixel(px[i], py[i]);
         n_checks++;
         if (rgb !== pe[i]) begin n_errors++; $display("FAIL snapshot (%0d,%0d) got %h want %h", px[i], py[i], rgb, pe[i]); end
         if (i == 3) bus.selected_cell = 7'd45;
      end
   endtask

   task automatic test_cursor();
      int px[5] = '{23, 35, 33, 35, 37};
      int py[5] = '{16, 27, 28, 28, 28};
      logic [11:0] pe[5] = '{12'hF00, 12'hFF0, 12'hFF0, 12'h00A, 12'hFF0};
      wait_pixel(3, 4);
      n_checks++; if (rgb !== 12'hFFF) begin n_errors++; $display("FAIL cursor_moved got %h want FFF", rgb); end
      wait_pixel(0, 10);
      bus.cell_state_flat[23*4 +: 4] = 4'd3;
      for (int i = 0; i < 5; i++) begin
         wait_pixel(px[i], py[i]);
         n_checks++;
         if (rgb !== pe[i]) begin n_errors++; $display("FAIL cursor (%0d,%0d) got %h want %h", px[i], py[i], rgb, pe[i]); end
      end
      bus.selected_cell = 7'd100;
      bus.cell_state_flat[37*4 +: 4] = 4'd7;
   endtask

   task automatic test_update();
      int px[4] = '{23, 47, 35, 33};
      int py[4] = '{16, 22, 27, 28};
      logic [11:0] pe[4] = '{12'h800, 12'h00A, 12'h00A, 12'h00A};
      for (int i = 0; i < 4; i++) begin
         wait_pixel(px[i], py[i]);
         n_checks++;
         if (rgb !== pe[i]) begin n_errors++; $display("FAIL update (%0d,%0d) got %h want %h", px[i], py[i], rgb, pe[i]); end
      end
   endtask

   task automatic test_mid_reset();
      int px[3] = '{3, 5, 23};
      int py[3] = '{4, 4, 16};
      logic [11:0] pe[3] = '{12'hFF0, 12'h00A, 12'h00A};
      wait_pixel(28, 40);
      reset = 1'b1;
      @(negedge clk);
      n_checks++; if (rgb !== 12'h000) begin n_errors++; $display("FAIL midreset_rgb got %h want 000", rgb); end
      n_checks++; if (bus.vga_hsync !== 1'b1) begin n_errors++; $display("FAIL midreset_hsync got %b want 1", bus.vga_hsync); end
      n_checks++; if (bus.vga_vsync !== 1'b1) begin n_errors++; $display("FAIL midreset_vsync got %b want 1", bus.vga_vsync); end
      n_checks++; if (bus.frame_start !== 1'b0) begin n_errors++; $display("FAIL midreset_fs got %b want 0", bus.frame_start); end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wait_pixel(px[i], py[i]);
         n_checks++;
         if (rgb !== pe[i]) begin n_errors++; $display("FAIL after_reset (%0d,%0d) got %h want %h", px[i], py[i], rgb, pe[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_hsync();
      test_vsync();
      test_frame_start(1);
      test_snapshot();
      test_frame_start(2);
      test_cursor();
      test_update();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
